// File: rtl/uart_pkg.sv
// ============================================================================
// Package     : uart_pkg
// Description : Shared definitions for the UART transmit serializer: the FSM
//               state encoding and the serial-line level constants.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // FSM state encoding (3 bits covers all five states)
  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Serial line levels: mark (idle / stop) and space (start)
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_bit_index.sv
// ============================================================================
// Module      : uart_bit_index
// Description : Loadable up-counter with terminal-count flag. Reused for the
//               data-bit index and for counting stop bits. The count never
//               moves past the supplied terminal value.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_bit_index
  import uart_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,     // restart the count at zero
  input  logic             advance,  // step by one (ignored at terminal)
  input  logic [WIDTH-1:0] last,     // terminal value for the current phase
  output logic             at_last
);

  logic [WIDTH-1:0] count;

  // Count register: load wins over advance; advance saturates at terminal
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (advance && !at_last) begin
      count <= count + 1'b1;
    end
  end

  assign at_last = (count == last);

endmodule : uart_bit_index

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
// Module      : uart_tx_serializer
// Description : Frames one DATA_WIDTH-bit word onto a serial line, LSB first:
//               start bit, data bits, optional even-parity bit, stop bit(s).
//               Bit timing comes only from the one-cycle bit_tick pulse of an
//               external tick counter, which this block enables via baud_en
//               while a frame is in flight.
//               Optional feature macro: UART_TX_PARITY_EN (adds parity bit).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  bit_tick,
  output logic                  baud_en,
  output logic                  tx_line,
  output logic                  busy,
  output logic                  tx_done
);

  // Index must hold DATA_WIDTH-1 and STOP_BITS-1; at least one bit wide
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  uart_state_t           state;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  line_r;
  logic                  done_r;
  logic                  accept;

  logic                  idx_load;
  logic                  idx_adv;
  logic [IDX_W-1:0]      idx_last;
  logic                  idx_at_last;

  // Ready is a decode of the state register, so no input reaches an output
  // without passing through a flop.
  assign tx_ready = (state == ST_IDLE);
  assign busy     = ~tx_ready;
  assign baud_en  = (state != ST_IDLE);
  assign tx_line  = line_r;
  assign tx_done  = done_r;
  assign accept   = tx_valid && tx_ready;

  // Index control: restart at each phase entry, step on ticks in DATA/STOP
  always_comb begin
    idx_last = (state == ST_STOP) ? STOP_LAST : DATA_LAST;
    idx_adv  = bit_tick && ((state == ST_DATA) || (state == ST_STOP));
    idx_load = (state == ST_IDLE) ||
               (bit_tick && ((state == ST_START) || (state == ST_PARITY) ||
                             ((state == ST_DATA) && idx_at_last)));
  end

  uart_bit_index #(
    .WIDTH (IDX_W)
  ) u_bit_index (
    .clk     (clk),
    .reset   (reset),
    .load    (idx_load),
    .advance (idx_adv),
    .last    (idx_last),
    .at_last (idx_at_last)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_r;

  // Even parity of the accepted word, captured alongside it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_r <= 1'b0;
    end else if (accept) begin
      parity_r <= ^tx_data;
    end
  end
`endif

  // Frame FSM: each non-idle state holds the line until a tick is sampled.
  // The word is shifted right as each bit is presented, so shreg[0] is
  // always the next data bit to drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      line_r <= LINE_IDLE;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A tick arriving here is deliberately ignored
          if (accept) begin
            shreg  <= tx_data;
            line_r <= LINE_START;
            state  <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            line_r <= shreg[0];
            shreg  <= shreg >> 1;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (!idx_at_last) begin
              line_r <= shreg[0];
              shreg  <= shreg >> 1;
            end else begin
`ifdef UART_TX_PARITY_EN
              line_r <= parity_r;
              state  <= ST_PARITY;
`else
              line_r <= LINE_IDLE;
              state  <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            line_r <= LINE_IDLE;
            state  <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick && idx_at_last) begin
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: begin
          line_r <= LINE_IDLE;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : uart_tx_serializer

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
// ============================================================================
// Module      : tb_uart_tx_serializer
// Description : Self-checking bench for uart_tx_serializer. Two instances
//               (one and two stop bits) share the stimulus; a selector picks
//               which one is driven and observed. Expected frames come from
//               a bit-list model of the UART framing rules.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic       tick  = 1'b0;
  logic       sel   = 1'b0;

  logic v0, t0, rdy0, ben0, ln0, bsy0, dn0;
  logic v1, t1, rdy1, ben1, ln1, bsy1, dn1;
  logic rdy, ben, ln, bsy, dn;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign v0  = valid & ~sel;
  assign t0  = tick  & ~sel;
  assign v1  = valid &  sel;
  assign t1  = tick  &  sel;
  assign rdy = sel ? rdy1 : rdy0;
  assign ben = sel ? ben1 : ben0;
  assign ln  = sel ? ln1  : ln0;
  assign bsy = sel ? bsy1 : bsy0;
  assign dn  = sel ? dn1  : dn0;

  uart_tx_serializer #(.DATA_WIDTH(8), .STOP_BITS(1)) dut_s1 (
    .clk(clk), .reset(reset), .tx_data(data), .tx_valid(v0), .tx_ready(rdy0),
    .bit_tick(t0), .baud_en(ben0), .tx_line(ln0), .busy(bsy0), .tx_done(dn0)
  );

  uart_tx_serializer #(.DATA_WIDTH(8), .STOP_BITS(2)) dut_s2 (
    .clk(clk), .reset(reset), .tx_data(data), .tx_valid(v1), .tx_ready(rdy1),
    .bit_tick(t1), .baud_en(ben1), .tx_line(ln1), .busy(bsy1), .tx_done(dn1)
  );

  typedef struct {
    logic [15:0] b;
    int          n;
  } frame_t;

  typedef struct {
    logic       s;         // 0: one stop bit, 1: two stop bits
    logic [7:0] w;
    logic       par;       // hand-computed even parity of w
    bit         tick_acc;  // tick coincident with accept
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Frame as an ordered list of line levels, one per bit period
  function automatic frame_t build(input logic [7:0] w, input int nstop, input logic par);
    frame_t f;
    f.b = '0;
    f.n = 0;
    f.b[f.n] = 1'b0; f.n++;
    for (int i = 0; i < 8; i++) begin
      f.b[f.n] = w[i]; f.n++;
    end
    if (PAR_EN) begin
      f.b[f.n] = par; f.n++;
    end
    for (int s = 0; s < nstop; s++) begin
      f.b[f.n] = 1'b1; f.n++;
    end
    return f;
  endfunction

  // Send one word (or observe an already-accepted one) with a tick every
  // 4 clocks; ends on the tx_done cycle.
  task automatic do_frame(input logic s, input logic [7:0] w, input logic par,
                          input bit pre_acc, input bit hold, input logic [7:0] next_w,
                          input bit tick_acc);
    frame_t f;
    f = build(w, s ? 2 : 1, par);
    if (!pre_acc) begin
      sel = s;
      @(negedge clk);
      chk("idle_ready", {15'd0, rdy}, 16'd1);
      chk("idle_done_low", {15'd0, dn}, 16'd0);
      chk("idle_line", {15'd0, ln}, 16'd1);
      data  = w;
      valid = 1'b1;
      tick  = tick_acc;
    end
    @(negedge clk);
    tick  = 1'b0;
    valid = hold;
    data  = hold ? next_w : ~w;
    for (int i = 0; i < f.n; i++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("bit%0d_line", i), {15'd0, ln}, {15'd0, f.b[i]});
        chk("frame_busy", {15'd0, bsy}, 16'd1);
        chk("frame_ready_low", {15'd0, rdy}, 16'd0);
        chk("frame_baud_en", {15'd0, ben}, 16'd1);
        chk("frame_no_done", {15'd0, dn}, 16'd0);
        if (c == 3) tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        if (!hold) data = 8'($urandom);
      end
    end
    chk("done_pulse", {15'd0, dn}, 16'd1);
    chk("done_ready", {15'd0, rdy}, 16'd1);
    chk("done_baud_en_low", {15'd0, ben}, 16'd0);
    chk("done_line_idle", {15'd0, ln}, 16'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    tbl = '{ '{1'b0, 8'hA5, 1'b0, 1'b0},
             '{1'b0, 8'h01, 1'b1, 1'b0},
             '{1'b0, 8'h80, 1'b1, 1'b1},
             '{1'b1, 8'h3C, 1'b0, 1'b0},
             '{1'b1, 8'h7F, 1'b1, 1'b1},
             '{1'b0, 8'hFF, 1'b0, 1'b0} };

    // Reset state of both instances
    repeat (2) @(negedge clk);
    chk("rst_line_s1", {15'd0, ln0}, 16'd1);
    chk("rst_ready_s1", {15'd0, rdy0}, 16'd1);
    chk("rst_busy_s1", {15'd0, bsy0}, 16'd0);
    chk("rst_baud_s1", {15'd0, ben0}, 16'd0);
    chk("rst_done_s1", {15'd0, dn0}, 16'd0);
    chk("rst_line_s2", {15'd0, ln1}, 16'd1);
    chk("rst_ready_s2", {15'd0, rdy1}, 16'd1);
    chk("rst_baud_s2", {15'd0, ben1}, 16'd0);
    reset = 1'b0;

    // Table-driven frames
    for (int k = 0; k < 6; k++) begin
      do_frame(tbl[k].s, tbl[k].w, tbl[k].par, 1'b0, 1'b0, 8'h00, tbl[k].tick_acc);
    end

    // Back-to-back with valid held high: 00 then FF, no idle gap
    do_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    do_frame(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    do_frame(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h96, 1'b0);
    do_frame(1'b1, 8'h96, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Valid pulsed between edges: never sampled, nothing sent
    sel = 1'b0;
    @(negedge clk);
    data  = 8'h55;
    valid = 1'b1;
    #2 valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("no_accept_line", {15'd0, ln}, 16'd1);
      chk("no_accept_ready", {15'd0, rdy}, 16'd1);
    end

    // Reset mid-DATA after three ticks
    @(negedge clk);
    data  = 8'hC3;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
    chk("pre_reset_line_d2", {15'd0, ln}, 16'd0);
    chk("pre_reset_busy", {15'd0, bsy}, 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_line", {15'd0, ln}, 16'd1);
    chk("async_rst_ready", {15'd0, rdy}, 16'd1);
    chk("async_rst_busy", {15'd0, bsy}, 16'd0);
    chk("async_rst_baud", {15'd0, ben}, 16'd0);
    @(negedge clk);
    chk("rst_hold_done", {15'd0, dn}, 16'd0);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick = (c % 4 == 3);
      @(negedge clk);
      tick = 1'b0;
      chk("post_rst_no_done", {15'd0, dn}, 16'd0);
      chk("post_rst_line", {15'd0, ln}, 16'd1);
    end
    do_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Randomized frames against the framing model
    for (int k = 0; k < 16; k++) begin
      logic [7:0] w;
      logic       p;
      w = 8'($urandom);
      p = 1'($countones(w) % 2);
      do_frame(1'($urandom_range(0, 1)), w, p, 1'b0, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    chk("final_done_low", {15'd0, dn}, 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_uart_tx_serializer

`default_nettype wire
